// File: rtl/trigger_receiver.sv
// trigger_receiver: receive side of the single-cycle trigger pulse interface.
// Synchronizes an asynchronous trigger line, detects the active edge, qualifies
// it against a minimum width, waits a programmable delay, emits a one-cycle
// pulse, then ignores edges for a holdoff window. Fired, rejected and missed
// events are counted with saturating counters for host readback.
module trigger_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_BITS  = 8,
    parameter int DELAY_BITS  = 16,
    parameter int COUNT_BITS  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  invert,
    input  logic                  trig_in,
    input  logic [WIDTH_BITS-1:0] min_width,
    input  logic [DELAY_BITS-1:0] delay,
    input  logic [DELAY_BITS-1:0] holdoff,
    input  logic                  clear_counts,
    output logic                  pulse_out,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] event_count,
    output logic [COUNT_BITS-1:0] reject_count,
    output logic [COUNT_BITS-1:0] miss_count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUALIFY = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_FIRE    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam logic [WIDTH_BITS-1:0] W_ZERO = {WIDTH_BITS{1'b0}};
    localparam logic [WIDTH_BITS-1:0] W_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [DELAY_BITS-1:0] D_ZERO = {DELAY_BITS{1'b0}};
    localparam logic [DELAY_BITS-1:0] D_ONE  = {{(DELAY_BITS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_BITS-1:0] C_ZERO = {COUNT_BITS{1'b0}};

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] value);
        logic [COUNT_BITS-1:0] result;
        if (value == {COUNT_BITS{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   sample_s;
    logic                   edge_s;

    logic [2:0]             state_r;
    logic [2:0]             state_s;
    logic [WIDTH_BITS-1:0]  width_cnt_r;
    logic [WIDTH_BITS-1:0]  width_cnt_s;
    logic [DELAY_BITS-1:0]  time_cnt_r;
    logic [DELAY_BITS-1:0]  time_cnt_s;
    logic [WIDTH_BITS-1:0]  min_width_r;
    logic [WIDTH_BITS-1:0]  min_width_s;
    logic [DELAY_BITS-1:0]  delay_r;
    logic [DELAY_BITS-1:0]  delay_s;
    logic [DELAY_BITS-1:0]  holdoff_r;
    logic [DELAY_BITS-1:0]  holdoff_s;
    logic [WIDTH_BITS-1:0]  min_width_eff_s;

    logic                   fire_s;
    logic                   reject_s;
    logic                   miss_s;
    logic                   width_done_s;
    logic                   delay_done_s;
    logic                   holdoff_done_s;

    logic                   pulse_r;
    logic                   busy_r;
    logic [COUNT_BITS-1:0]  event_r;
    logic [COUNT_BITS-1:0]  reject_r;
    logic [COUNT_BITS-1:0]  miss_r;

    // Polarity-adjusted synchronized sample and its inactive->active edge.
    assign sample_s = sync_r[SYNC_STAGES-1] ^ invert;
    assign edge_s   = sample_s & ~prev_r;

    // A programmed width of 0 behaves exactly like 1.
    assign min_width_eff_s = (min_width == W_ZERO) ? W_ONE : min_width;

    // Terminal-count tests, evaluated with one spare bit so +1 never wraps.
    assign width_done_s   = ({1'b0, width_cnt_r} + {W_ZERO, 1'b1}) >= {1'b0, min_width_r};
    assign delay_done_s   = ({1'b0, time_cnt_r} + {D_ZERO, 1'b1}) >= {1'b0, delay_r};
    assign holdoff_done_s = ({1'b0, time_cnt_r} + {D_ZERO, 1'b1}) >= {1'b0, holdoff_r};

    // Next-state, counter and configuration-latch logic of the event FSM.
    always_comb begin
        state_s     = state_r;
        width_cnt_s = width_cnt_r;
        time_cnt_s  = time_cnt_r;
        min_width_s = min_width_r;
        delay_s     = delay_r;
        holdoff_s   = holdoff_r;
        fire_s      = 1'b0;
        reject_s    = 1'b0;
        miss_s      = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        min_width_s = min_width_eff_s;
                        delay_s     = delay;
                        holdoff_s   = holdoff;
                        time_cnt_s  = D_ZERO;
                        width_cnt_s = W_ONE;
                        // The edge cycle itself already satisfies a width of 1.
                        if (min_width_eff_s != W_ONE) begin
                            state_s = ST_QUALIFY;
                        end else if (delay == D_ZERO) begin
                            state_s = ST_FIRE;
                        end else begin
                            state_s = ST_DELAY;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_QUALIFY: begin
                    if (!sample_s) begin
                        reject_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else if (width_done_s) begin
                        time_cnt_s = D_ZERO;
                        if (delay_r == D_ZERO) begin
                            state_s = ST_FIRE;
                        end else begin
                            state_s = ST_DELAY;
                        end
                    end else begin
                        width_cnt_s = width_cnt_r + W_ONE;
                    end
                end
                ST_DELAY: begin
                    if (delay_done_s) begin
                        state_s = ST_FIRE;
                    end else begin
                        time_cnt_s = time_cnt_r + D_ONE;
                    end
                end
                ST_FIRE: begin
                    fire_s     = 1'b1;
                    time_cnt_s = D_ZERO;
                    if (holdoff_r == D_ZERO) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (holdoff_done_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        time_cnt_s = time_cnt_r + D_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
            // Edges arriving after qualification are only tallied.
            if ((state_r == ST_DELAY) || (state_r == ST_FIRE) || (state_r == ST_HOLDOFF)) begin
                miss_s = edge_s;
            end else begin
                miss_s = 1'b0;
            end
        end
    end

    // Synchronizer chain and edge history; history resets to "active".
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], trig_in};
            prev_r <= sample_s;
        end
    end

    // FSM state, internal counters and latched configuration.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            width_cnt_r <= W_ZERO;
            time_cnt_r  <= D_ZERO;
            min_width_r <= W_ONE;
            delay_r     <= D_ZERO;
            holdoff_r   <= D_ZERO;
        end else begin
            state_r     <= state_s;
            width_cnt_r <= width_cnt_s;
            time_cnt_r  <= time_cnt_s;
            min_width_r <= min_width_s;
            delay_r     <= delay_s;
            holdoff_r   <= holdoff_s;
        end
    end

    // Registered pulse and busy, both derived from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            pulse_r <= (state_s == ST_FIRE);
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Saturating event counters; a clear strobe beats a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            event_r  <= C_ZERO;
            reject_r <= C_ZERO;
            miss_r   <= C_ZERO;
        end else begin
            if (fire_s) begin
                event_r <= sat_inc(event_r);
            end
            if (reject_s) begin
                reject_r <= sat_inc(reject_r);
            end
            if (miss_s) begin
                miss_r <= sat_inc(miss_r);
            end
        end
    end

    assign pulse_out    = pulse_r;
    assign busy         = busy_r;
    assign event_count  = event_r;
    assign reject_count = reject_r;
    assign miss_count   = miss_r;

endmodule

// File: doc/trigger_receiver.md
Name: trigger_receiver

Overview:
Receive side of the single-cycle trigger pulse interface. Takes an asynchronous external trigger line and synchronizes it. Qualifies the active edge against a minimum width, waits a programmable delay, then emits a one-cycle pulse_out. After each pulse, a holdoff window ignores further edges, and fired/rejected/missed events are counted for host readback.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the trig_in synchronizer (>=2)
WIDTH_BITS, 8, width of min_width and of the qualification counter
DELAY_BITS, 16, width of delay and holdoff and of their counters
COUNT_BITS, 16, width of the event/reject/miss counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  1 = receiver armed; 0 = forced to IDLE
invert  in  1  0 = rising edge active; 1 = falling edge active
trig_in  in  1  asynchronous external trigger
min_width  in  WIDTH_BITS  required active length in synchronized cycles (0 treated as 1)
delay  in  DELAY_BITS  cycles from qualification to pulse
holdoff  in  DELAY_BITS  dead cycles after the pulse
clear_counts  in  1  one-cycle strobe, zeroes all counters
pulse_out  out  1  one-cycle qualified trigger
busy  out  1  high in any state except IDLE
event_count  out  COUNT_BITS  pulses fired
reject_count  out  COUNT_BITS  edges failing width qualification
miss_count  out  COUNT_BITS  edges ignored while busy

Behaviour:
- Interface: reset is synchronous, active-high. The clock is named clock.
- Reset: every output is 0. Synchronizer stages reset to 0. The edge-detect history register (polarity-adjusted) resets to "active", so a level already active at reset release, or while enable=0, never fires.
- Polarity-adjusted sample: s = sync_out XOR invert. An edge is the cycle where s=1 and the previous s=0.
- FSM states: IDLE, QUALIFY, DELAY, FIRE, HOLDOFF.
- Config latch: min_width, delay and holdoff are latched at the edge cycle in IDLE. Later input changes do not affect an event in progress.
- IDLE -> QUALIFY on edge with enable=1. The width counter starts at 1, counting the edge cycle.
- QUALIFY:
  - If s=0 before the count reaches max(min_width,1): reject_count++ and go to IDLE.
  - On reaching the count: go to DELAY, or to FIRE when delay=0.
- DELAY: counts delay cycles, then goes to FIRE.
- FIRE: pulse_out=1 for exactly one cycle and event_count++. Then go to HOLDOFF, or to IDLE when holdoff=0.
- HOLDOFF: counts holdoff cycles, then goes to IDLE.
- Latency: let trig_in be first sampled active at clock edge k, and W = max(min_width,1). pulse_out is high in the cycle following edge k + SYNC_STAGES + (W-1) + delay. Example: W=1, delay=0, SYNC_STAGES=2 -> high after edge k+2.
- Missed edges: any edge detected in DELAY, FIRE or HOLDOFF increments miss_count and is otherwise ignored. Edges during QUALIFY cannot occur, because s must stay high. After returning to IDLE, a new inactive->active transition is required to start another event.
- enable=0 in any state: IDLE on the next edge, with no pulse. An in-progress event is dropped and not counted.
- Counters saturate at all-ones, with no wrap.
- clear_counts has priority over a simultaneous increment; the result is 0.
- Reset mid-operation (any state): IDLE, pulse_out=0, counters 0, on the next cycle.
- busy is registered and equals (state != IDLE).

Test Plan:
1. min_width=0, delay=0, holdoff=0, trig_in high at edge 10 for 5 cycles -> pulse_out high only in the cycle after edge 12; event_count=1; busy high for that event only.
2. min_width=4, delay=0: 3-cycle high glitch -> no pulse, reject_count=1. Then a 6-cycle high starting at edge 40 -> pulse after edge 45, event_count=1.
3. delay=5, holdoff=10: edges at 20 and 28 -> one pulse (after edge 27), miss_count=1. Edge at 60 -> second pulse after edge 67.
4. invert=1, trig_in held low through reset release -> no pulse. Rise then fall at edge 30 -> pulse after edge 32.
5. Reset asserted during DELAY -> no pulse, all counters 0. Separately, enable dropped mid-HOLDOFF -> busy=0 next cycle, and the next edge after re-enable fires normally.
6. COUNT_BITS=4 override, 20 qualified events -> event_count=15. clear_counts pulsed on the same cycle as the 21st pulse -> event_count=0.
